cp_host: RTL
============

Name: cp_host

Overview:
- Host-side initiator for the 4-bit CP nibble port, the port the cartridge-side Primary logic answers as responder.
- Turns byte commands from local logic into four-phase nibble transfers on CPData, CPStrobe, CPDir and CPReady.
- Drives CPReset as well.
- Sits in a bench/bridge FPGA or the test harness that programs and controls the Xport through its CP port.

Parameters:
SETUP_CYCLES, 2, Clk cycles CPData/CPDir are held stable before CPStrobe rises (min 1).
TIMEOUT_CYCLES, 1024, Clk cycles to wait for any CPReady edge before abort.
RESET_CYCLES, 16, width of a CPReset pulse in Clk cycles.

Ports:
Clk  input  1  system clock; all logic rising-edge.
Reset  input  1  synchronous, active-high reset.
CmdValid  input  1  byte command offered.
CmdReady  output  1  command accepted this cycle when CmdValid & CmdReady.
CmdWrite  input  1  1 = write byte to device, 0 = read byte.
CmdData  input  8  write byte; ignored for reads.
RspValid  output  1  one-cycle pulse: read byte available.
RspData  output  8  read byte; valid with RspValid, held until next read completes.
PortResetReq  input  1  request a CPReset pulse; honoured only in IDLE.
CPDataOut  output  4  nibble driven toward device.
CPDataOe  output  1  1 = drive CPData (writes only).
CPDataIn  input  4  nibble from device (asynchronous).
CPReady  input  1  device handshake (asynchronous).
CPReset  output  1  device port reset, active high.
CPDir  output  1  1 = host-to-device, 0 = device-to-host.
CPStrobe  output  1  host handshake.
Busy  output  1  high whenever state != IDLE.
Error  output  1  sticky timeout flag; cleared by Reset or next accepted command.

Behaviour:
- Reset values: CmdReady=0, RspValid=0, RspData=0, CPDataOut=0, CPDataOe=0, CPReset=0, CPDir=0, CPStrobe=0, Busy=0, Error=0.
- State goes to IDLE on the cycle after Reset is sampled high, including mid-transfer. The device sees strobe fall and must recover.
- CPReady and CPDataIn pass through 2-flop synchronizers. The effective handshake edge is seen 2 Clk after the pin changes.
- Byte = two nibbles, low nibble first. Nibble index 0, then 1.
- CmdReady = 1 only in IDLE with PortResetReq low. PortResetReq has priority over CmdValid in the same cycle.
- States:
  - IDLE: on accept, latch CmdWrite/CmdData, set CPDir, set CPDataOe=CmdWrite, load the nibble, go to SETUP.
  - SETUP: count SETUP_CYCLES, then CPStrobe=1, go to WAIT_HI.
  - WAIT_HI: wait for synced CPReady=1. On a read, capture the synced CPDataIn into the nibble slot in the same cycle. Then CPStrobe=0, go to WAIT_LO.
  - WAIT_LO: wait for synced CPReady=0.
    - If nibble 0: load nibble 1, go to SETUP.
    - Else: CPDataOe=0. On a read, pulse RspValid with the assembled byte. Go to IDLE.
  - PRESET: CPReset=1 for RESET_CYCLES, then 0, go to IDLE. CPStrobe held 0 throughout.
- CPDir and CPDataOut stay constant from SETUP entry until WAIT_LO exit.
- Best-case byte latency, accept to IDLE: 2*(SETUP_CYCLES+1) + handshake + synchronizer delays. With an instant device and SETUP=2: 2*(1+2+3+3)=18 Clk.
- CPReady already high on IDLE exit: SETUP proceeds normally. WAIT_HI completes immediately after strobe; the device contract forbids this state.
- Timeout counter resets on each state entry. It saturates at TIMEOUT_CYCLES.

Optional Feature:
- Macro: CP_HOST_TIMEOUT_EN.
- Defined: in WAIT_HI/WAIT_LO, reaching TIMEOUT_CYCLES forces CPStrobe=0, CPDataOe=0 and Error=1. Goes to IDLE with no RspValid and drops the partial byte.
- Undefined: no counter is built, waits are unbounded, and Error is tied 0.

Decomposition:
- Shared package (cp_pkg): state encoding, CP_DIR_WRITE=1 / CP_DIR_READ=0, NIBBLE_LO_FIRST constant. Reused by the responder-side bench model.
- One sub-module: cp_sync, a parameterised-width 2-flop synchronizer, instantiated for {CPReady, CPDataIn}.

Test Plan:
- Write 0xA5, device model acks after 3 Clk: CPDataOut 0x5 then 0xA, CPDir=1, CPDataOe=1 only during transfer, Busy falls, no RspValid, Error=0.
- Read with device returning nibbles 0xC then 0x3: exactly one RspValid pulse with RspData=0x3C. CPDataOe stays 0, CPDir=0.
- PortResetReq and CmdValid high together in IDLE: CPReset high exactly 16 Clk, CmdReady=0 meanwhile. The command is accepted the first IDLE cycle after.
- CP_HOST_TIMEOUT_EN, device never raises CPReady: strobe drops after 1024 Clk in WAIT_HI, Error=1, back in IDLE. The next accepted command clears Error.
- Reset asserted in WAIT_LO of nibble 1 during a read: all outputs at reset values next cycle, no RspValid. A following write 0x0F completes normally.
- Back-to-back writes 0x12, 0x34 with CmdValid held: second accepted the cycle IDLE is re-entered. Nibble sequence is 2, 1, 4, 3.

Source files
------------

// File: rtl/cp_pkg.sv
// Shared CP nibble-port definitions: FSM encoding, direction values and nibble order.
// Used by the cp_host initiator and by responder-side models.
package cp_pkg;

    typedef logic [2:0] cp_state_t;

    localparam cp_state_t ST_IDLE    = 3'd0;
    localparam cp_state_t ST_SETUP   = 3'd1;
    localparam cp_state_t ST_WAIT_HI = 3'd2;
    localparam cp_state_t ST_WAIT_LO = 3'd3;
    localparam cp_state_t ST_PRESET  = 3'd4;

    localparam logic CP_DIR_WRITE = 1'b1;
    localparam logic CP_DIR_READ  = 1'b0;

    localparam logic NIBBLE_LO_FIRST = 1'b1;

    // True when transfer index idx carries bits [7:4] of the byte.
    function automatic logic nibble_is_hi(input logic idx);
        return idx ^ !NIBBLE_LO_FIRST;
    endfunction

    function automatic logic [3:0] nibble_of(input logic [7:0] b, input logic idx);
        return nibble_is_hi(idx) ? b[7:4] : b[3:0];
    endfunction

endpackage

// File: rtl/cp_host_if.sv
// Command and CP-port signal bundle for cp_host.
// master = the cp_host initiator, slave = local logic plus the device pins.
interface cp_host_if;
    logic       CmdValid;
    logic       CmdReady;
    logic       CmdWrite;
    logic [7:0] CmdData;
    logic       RspValid;
    logic [7:0] RspData;
    logic       PortResetReq;
    logic [3:0] CPDataOut;
    logic       CPDataOe;
    logic [3:0] CPDataIn;
    logic       CPReady;
    logic       CPReset;
    logic       CPDir;
    logic       CPStrobe;
    logic       Busy;
    logic       Error;

    modport master (
        input  CmdValid, CmdWrite, CmdData, PortResetReq, CPDataIn, CPReady,
        output CmdReady, RspValid, RspData, CPDataOut, CPDataOe, CPReset,
               CPDir, CPStrobe, Busy, Error
    );

    modport slave (
        output CmdValid, CmdWrite, CmdData, PortResetReq, CPDataIn, CPReady,
        input  CmdReady, RspValid, RspData, CPDataOut, CPDataOe, CPReset,
               CPDir, CPStrobe, Busy, Error
    );
endinterface

// File: rtl/cp_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous device pins.
module cp_sync #(
    parameter int WIDTH = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cp_host.sv
// Host-side initiator turning byte commands into four-phase CP nibble transfers.
// Optional macro CP_HOST_TIMEOUT_EN adds a handshake timeout with a sticky Error flag.
module cp_host
    import cp_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RESET_CYCLES   = 16
) (
    input  logic      Clk,
    input  logic      Reset,
    cp_host_if.master bus
);

`ifdef CP_HOST_TIMEOUT_EN
    localparam int TO_MAX = TIMEOUT_CYCLES;
`else
    localparam int TO_MAX = 0;
`endif
    localparam int MAX_AB  = (SETUP_CYCLES > RESET_CYCLES) ? SETUP_CYCLES : RESET_CYCLES;
    localparam int CNT_MAX = (MAX_AB > TO_MAX) ? MAX_AB : TO_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    cp_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             wr_q;
    logic [7:0]       byte_q;
    logic             nib_idx;
    logic [3:0]       data_out;
    logic             data_oe;
    logic             dir;
    logic             strobe;
    logic             cp_reset;
    logic             rsp_valid;
    logic [7:0]       rsp_data;
    logic             error;
    logic             ready_s;
    logic [3:0]       data_s;
    logic             cmd_ready;
    logic             accept;
    logic             timeout_abort;

    cp_sync #(.WIDTH(5)) u_sync (
        .Clk   (Clk),
        .Reset (Reset),
        .d     ({bus.CPReady, bus.CPDataIn}),
        .q     ({ready_s, data_s})
    );

    // PortResetReq wins over a same-cycle command.
    assign cmd_ready = (state == ST_IDLE) && !bus.PortResetReq && !Reset;
    assign accept    = cmd_ready && bus.CmdValid;

`ifdef CP_HOST_TIMEOUT_EN
    logic timeout_hit;

    assign timeout_hit   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_abort = timeout_hit &&
                           (((state == ST_WAIT_HI) && !ready_s) ||
                            ((state == ST_WAIT_LO) &&  ready_s));

    always_ff @(posedge Clk) begin
        if (Reset)              error <= 1'b0;
        else if (accept)        error <= 1'b0;
        else if (timeout_abort) error <= 1'b1;
    end
`else
    assign timeout_abort = 1'b0;
    assign error         = 1'b0;
`endif

    // NOTE: all FSM state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            byte_q    <= '0;
            nib_idx   <= 1'b0;
            data_out  <= '0;
            data_oe   <= 1'b0;
            dir       <= 1'b0;
            strobe    <= 1'b0;
            cp_reset  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (bus.PortResetReq) begin
                        cp_reset <= 1'b1;
                        state    <= ST_PRESET;
                    end else if (bus.CmdValid) begin
                        wr_q     <= bus.CmdWrite;
                        byte_q   <= bus.CmdWrite ? bus.CmdData : 8'h00;
                        nib_idx  <= 1'b0;
                        dir      <= bus.CmdWrite ? CP_DIR_WRITE : CP_DIR_READ;
                        data_oe  <= bus.CmdWrite;
                        data_out <= bus.CmdWrite ? nibble_of(bus.CmdData, 1'b0) : 4'h0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
                        cnt    <= '0;
                        strobe <= 1'b1;
                        state  <= ST_WAIT_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_HI: begin
                    if (ready_s) begin
                        if (!wr_q) begin
                            if (nibble_is_hi(nib_idx)) byte_q[7:4] <= data_s;
                            else                       byte_q[3:0] <= data_s;
                        end
                        cnt    <= '0;
                        strobe <= 1'b0;
                        state  <= ST_WAIT_LO;
                    end else if (timeout_abort) begin
                        cnt     <= '0;
                        strobe  <= 1'b0;
                        data_oe <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!ready_s) begin
                        cnt <= '0;
                        if (!nib_idx) begin
                            nib_idx  <= 1'b1;
                            data_out <= wr_q ? nibble_of(byte_q, 1'b1) : 4'h0;
                            state    <= ST_SETUP;
                        end else begin
                            data_oe <= 1'b0;
                            if (!wr_q) begin
                                rsp_valid <= 1'b1;
                                rsp_data  <= byte_q;
                            end
                            state <= ST_IDLE;
                        end
                    end else if (timeout_abort) begin
                        cnt     <= '0;
                        data_oe <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PRESET: begin
                    if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
                        cnt      <= '0;
                        cp_reset <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.CmdReady  = cmd_ready;
    assign bus.RspValid  = rsp_valid;
    assign bus.RspData   = rsp_data;
    assign bus.CPDataOut = data_out;
    assign bus.CPDataOe  = data_oe;
    assign bus.CPReset   = cp_reset;
    assign bus.CPDir     = dir;
    assign bus.CPStrobe  = strobe;
    assign bus.Busy      = (state != ST_IDLE);
    assign bus.Error     = error;

endmodule
